// File: rtl/rand_draw_ctrl.sv
// rand_draw_ctrl: draws i_Count distinct values below i_Max from an external shuffling generator.
module rand_draw_ctrl #(
  parameter int N    = 4,
  parameter int SPIN = 3
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_fStart,
  input  logic         i_fAbort,
  input  logic [N-1:0] i_Max,
  input  logic [N-1:0] i_Count,
  output logic         o_fShuffle,
  output logic         o_fStop,
  output logic [N-1:0] o_LfsrMax,
  input  logic         i_fRdy,
  input  logic [N-1:0] i_Num,
  output logic         o_fValid,
  output logic [N-1:0] o_Num,
  output logic [N-1:0] o_Idx,
  output logic         o_fDone,
  output logic         o_fBusy,
  output logic         o_fErr
);
  typedef enum logic [2:0] {S_IDLE, S_KICK, S_SPIN, S_WAIT, S_CHECK, S_DONE} state_t;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  state_t            state_q, state_d;
  logic [N-1:0]      max_q, lim_q, drawn_q, num_q, idx_q;
  logic [7:0]        spin_q;
  logic [2**N-1:0]   used_q;
  logic              err_q, start_ok, hit, launch;
  logic [N-1:0]      next_cnt;
  assign start_ok = (i_Count != '0) && (i_Count <= i_Max);
  assign launch   = (state_q == S_IDLE) && i_fStart && !i_fAbort && start_ok;
  assign hit      = used_q[i_Num] || (i_Num >= max_q);
  assign next_cnt = drawn_q + ONE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = launch ? S_KICK : S_IDLE;
      S_KICK:  state_d = S_SPIN;
      S_SPIN:  state_d = (spin_q <= 8'd1) ? S_WAIT : S_SPIN;
      S_WAIT:  state_d = i_fRdy ? S_CHECK : S_WAIT;
      S_CHECK: state_d = (!hit && next_cnt == lim_q) ? S_DONE : S_KICK;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_fAbort) state_d = S_IDLE;
  end
  assign o_fShuffle = (state_q == S_KICK) && !i_fAbort;
  assign o_fStop    = (state_q == S_SPIN) && (spin_q <= 8'd1) && !i_fAbort;
  assign o_fValid   = (state_q == S_CHECK) && !hit && !i_fAbort;
  assign o_fDone    = (state_q == S_DONE) && !i_fAbort;
  assign o_fBusy    = state_q != S_IDLE;
  assign o_fErr     = err_q;
  assign o_LfsrMax  = max_q;
  // The accepted draw is visible in its own CHECK cycle, then held from the registers.
  assign o_Num      = o_fValid ? i_Num : num_q;
  assign o_Idx      = o_fValid ? drawn_q : idx_q;
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      max_q   <= '0;
      lim_q   <= '0;
      drawn_q <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      spin_q  <= '0;
      used_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == S_IDLE) && i_fStart && !i_fAbort && !start_ok;
      if (launch) begin
        max_q   <= i_Max;
        lim_q   <= i_Count;
        drawn_q <= '0;
        used_q  <= '0;
      end
      if (state_q == S_KICK) spin_q <= 8'(SPIN);
      else if (state_q == S_SPIN && spin_q != '0) spin_q <= spin_q - 8'd1;
      if (o_fValid) begin
        used_q[i_Num] <= 1'b1;
        num_q         <= i_Num;
        idx_q         <= drawn_q;
        drawn_q       <= next_cnt;
      end
    end
  end
endmodule
